// File: rtl/lpc_cycle_streamer.sv
// Captures LPC cycle records into a FIFO and replays each one as a 5-byte
// frame (sync byte + 4 record bytes, MSB first) on a valid/ready byte stream.
module lpc_cycle_streamer #(
  parameter int          DEPTH     = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [31:0]                lpc_tdata_i,
  input  logic                       lpc_ready_i,
  input  logic                       flush_i,
  input  logic                       clr_ovf_i,
  output logic [7:0]                 m_data_o,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic [7:0]                 ovf_cnt_o,
  output logic                       ovf_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {IDLE, HDR, B3, B2, B1, B0} state_t;

  state_t          state_q, state_d;
  logic            ready_q;
  logic [31:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [LW-1:0]   level_q, level_d;
  logic [31:0]     shreg_q;
  logic [7:0]      ovf_cnt_q;
  logic            ovf_q;

  logic push, full, pop, acc, drop;

  assign push = lpc_ready_i & ~ready_q;
  assign full = (level_q == LW'(DEPTH));
  assign pop  = (state_q == IDLE) && (level_q != '0) && !flush_i;
  // A full FIFO still takes the record when the head leaves on the same edge.
  assign acc  = push && !flush_i && (!full || pop);
  assign drop = push && !flush_i && full && !pop;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop)       state_d = HDR;
      HDR:     if (m_ready_i) state_d = B3;
      B3:      if (m_ready_i) state_d = B2;
      B2:      if (m_ready_i) state_d = B1;
      B1:      if (m_ready_i) state_d = B0;
      B0:      if (m_ready_i) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (flush_i) level_d = '0;
    else begin
      case ({acc, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_comb begin
    m_data_o = 8'h00;
    case (state_q)
      HDR:     m_data_o = SYNC_BYTE;
      B3:      m_data_o = shreg_q[31:24];
      B2:      m_data_o = shreg_q[23:16];
      B1:      m_data_o = shreg_q[15:8];
      B0:      m_data_o = shreg_q[7:0];
      default: m_data_o = 8'h00;
    endcase
  end

  // Valid is a decode of the state register only, so m_ready_i never reaches it.
  assign m_valid_o = (state_q != IDLE);
  assign level_o   = level_q;
  assign ovf_cnt_o = ovf_cnt_q;
  assign ovf_o     = ovf_q;

  always_ff @(posedge clk_i) begin
    if (acc) mem_q[wr_q] <= lpc_tdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      level_q   <= '0;
      shreg_q   <= '0;
      ovf_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= lpc_ready_i;
      level_q <= level_d;
      if (flush_i) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (acc) wr_q <= wr_q + AW'(1);
        if (pop) rd_q <= rd_q + AW'(1);
      end
      if (pop) shreg_q <= mem_q[rd_q];
      if (clr_ovf_i) begin
        ovf_cnt_q <= '0;
        ovf_q     <= 1'b0;
      end else if (drop) begin
        ovf_q <= 1'b1;
        if (ovf_cnt_q != 8'hFF) ovf_cnt_q <= ovf_cnt_q + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_lpc_cycle_streamer.sv
// Bench for lpc_cycle_streamer: expected stream bytes are queued as records
// are driven and compared by a monitor as the DUT hands them over.
module tb_lpc_cycle_streamer;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] lpc_tdata = '0;
  logic        lpc_ready = 1'b0;
  logic        flush = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  level;
  logic [7:0]  ovf_cnt;
  logic        ovf;

  lpc_cycle_streamer #(.DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
    .clk_i(clk), .rst_i(rst), .lpc_tdata_i(lpc_tdata), .lpc_ready_i(lpc_ready),
    .flush_i(flush), .clr_ovf_i(clr_ovf), .m_data_o(m_data), .m_valid_o(m_valid),
    .m_ready_i(m_ready), .level_o(level), .ovf_cnt_o(ovf_cnt), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  logic rand_rdy = 1'b0, rdy_val = 1'b0, rnd_rdy = 1'b0;
  assign m_ready = rand_rdy ? rnd_rdy : rdy_val;
  always @(posedge clk) begin
    #1 rnd_rdy = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stream monitor: byte order/content plus hold-while-stalled.
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = '0;
  always @(negedge clk) begin
    if (rst) stall_prev = 1'b0;
    else begin
      if (stall_prev) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(stall_data));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none", m_data);
        end else chk("stream_byte", 32'(m_data), 32'(exp_q.pop_front()));
      end
      stall_prev = m_valid && !m_ready;
      stall_data = m_data;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_frame(input logic [31:0] d);
    exp_q.push_back(8'hA5);
    exp_q.push_back(d[31:24]);
    exp_q.push_back(d[23:16]);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
  endtask

  task automatic pulse(input logic [31:0] d, input int len);
    lpc_tdata = d;
    lpc_ready = 1'b1;
    tick(len);
    lpc_ready = 1'b0;
    tick(1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    rand_rdy = 1'b1;
    while ((exp_q.size() != 0 || m_valid) && n < 3000) begin tick(1); n++; end
    rand_rdy = 1'b0;
    chk({name, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_idle"}, 32'(m_valid), 32'd0);
  endtask

  typedef struct {
    logic [31:0] d;
    int          hold;
    logic [39:0] frame;
  } vec_t;
  vec_t tbl[4];

  initial begin
    logic [31:0] d;
    tbl[0] = '{32'h0ABCD541, 2, 40'hA5_0A_BC_D5_41};
    tbl[1] = '{32'h00123482, 3, 40'hA5_00_12_34_82};
    tbl[2] = '{32'h0FFFFFC3, 6, 40'hA5_0F_FF_FF_C3};
    tbl[3] = '{32'h00000000, 2, 40'hA5_00_00_00_00};

    #1 rst = 1'b1;
    #2;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(2);

    // One frame per READY period regardless of pulse length
    rdy_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int k = 4; k >= 0; k--) exp_q.push_back(tbl[i].frame[8*k +: 8]);
      lpc_tdata = tbl[i].d;
      lpc_ready = 1'b1;
      tick(1);
      chk("tbl_level_push", 32'(level), 32'd1);
      tick(1);
      chk("tbl_level_pop", 32'(level), 32'd0);
      if (tbl[i].hold > 2) tick(tbl[i].hold - 2);
      lpc_ready = 1'b0;
      drain("tbl_drain");
    end

    // Backpressure in the middle of a frame
    rdy_val = 1'b0;
    push_frame(32'h0ABCD541);
    pulse(32'h0ABCD541, 1);
    chk("hdr_valid", 32'(m_valid), 32'd1);
    chk("hdr_data", 32'(m_data), 32'hA5);
    rdy_val = 1'b1;
    tick(2);
    rdy_val = 1'b0;
    repeat (3) begin
      chk("stall_valid", 32'(m_valid), 32'd1);
      chk("stall_data", 32'(m_data), 32'hBC);
      tick(1);
    end
    drain("stall_drain");

    // Overflow: first record goes straight to the shifter, 16 fill, 3 dropped
    rdy_val = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      d = 32'hC0DE0000 | 32'(i);
      if (i <= 17) push_frame(d);
      pulse(d, 1);
    end
    chk("full_level", 32'(level), 32'd16);
    chk("full_ovf_cnt", 32'(ovf_cnt), 32'd3);
    chk("full_ovf", 32'(ovf), 32'd1);
    chk("full_hdr", 32'(m_data), 32'hA5);

    // Push lands on the IDLE pop edge while full: accepted, not dropped
    rdy_val = 1'b1;
    tick(5);
    lpc_tdata = 32'h0F00BA12;
    lpc_ready = 1'b1;
    push_frame(32'h0F00BA12);
    tick(1);
    lpc_ready = 1'b0;
    chk("pop_push_level", 32'(level), 32'd16);
    chk("pop_push_ovf_cnt", 32'(ovf_cnt), 32'd3);
    drain("ovf_drain");
    chk("ovf_drain_level", 32'(level), 32'd0);

    // Saturation, then clear colliding with a drop
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    chk("clr_ovf_cnt", 32'(ovf_cnt), 32'd0);
    chk("clr_ovf", 32'(ovf), 32'd0);
    rdy_val = 1'b0;
    for (int i = 0; i < 317; i++) begin
      d = 32'h00AA0000 | 32'(i);
      if (i < 17) push_frame(d);
      pulse(d, 1);
    end
    chk("sat_ovf_cnt", 32'(ovf_cnt), 32'hFF);
    chk("sat_ovf", 32'(ovf), 32'd1);
    chk("sat_level", 32'(level), 32'd16);
    lpc_tdata = 32'h0DEAD001;
    lpc_ready = 1'b1;
    clr_ovf = 1'b1;
    tick(1);
    lpc_ready = 1'b0;
    clr_ovf = 1'b0;
    chk("clr_win_cnt", 32'(ovf_cnt), 32'd0);
    chk("clr_win_ovf", 32'(ovf), 32'd0);
    chk("clr_win_level", 32'(level), 32'd16);
    tick(1);
    drain("sat_drain");

    // Reset in the middle of a frame
    push_frame(32'h01234567);
    pulse(32'h01234567, 1);
    rdy_val = 1'b1;
    tick(3);
    rdy_val = 1'b0;
    chk("b1_data", 32'(m_data), 32'h45);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(m_valid), 32'd0);
    chk("midrst_data", 32'(m_data), 32'd0);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_left", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    tick(1);
    rst = 1'b0;
    tick(1);

    // Flush while in B3 with three queued records
    for (int k = 1; k <= 4; k++) begin
      d = {8'h30 + 8'(k), 8'h40, 8'h50, 8'h60 + 8'(k)};
      push_frame(d);
      pulse(d, 1);
    end
    chk("preflush_level", 32'(level), 32'd3);
    rdy_val = 1'b1;
    tick(1);
    rdy_val = 1'b0;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_frame_valid", 32'(m_valid), 32'd1);
    chk("flush_frame_b3", 32'(m_data), 32'h31);
    repeat (15) void'(exp_q.pop_back());
    drain("flush_drain");
    rdy_val = 1'b1;
    tick(10);
    chk("post_flush_valid", 32'(m_valid), 32'd0);
    chk("post_flush_level", 32'(level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
